// File: rtl/uart_axi_pkg.sv
// ============================================================================
// Module      : uart_axi_pkg
// Description : Shared types and constants for the UART AXI endpoints:
//               write-FSM and serializer state encodings, the UART character
//               width and the AXI OKAY response code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_axi_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } ser_state_t;

  localparam int         UART_DATA_BITS = 8;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

`default_nettype wire

// File: rtl/uart_tx_serializer.sv
// ============================================================================
// Module      : uart_tx_serializer
// Description : Serializes one byte per frame onto txd: start bit, 8 data
//               bits LSB first, optional even-parity bit, one stop bit.
//               Each bit lasts CLK_DIV clk cycles. txd is registered.
// Revision    : 1.0 - initial release
// Macro       : UART_TX_PARITY_EN - adds an even-parity bit before stop.
// Ports       : clk, rstn     - clock, synchronous active-low reset
//               tx_byte/valid - byte offered by the FIFO
//               ready         - high in S_IDLE; valid && ready pops a byte
//               txd           - serial output, idle high
//               active        - serializer is not in S_IDLE
// ============================================================================
`default_nettype none

module uart_tx_serializer import uart_axi_pkg::*; #(
  parameter int CLK_DIV = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [UART_DATA_BITS-1:0] tx_byte,
  input  logic                      valid,
  output logic                      ready,
  output logic                      txd,
  output logic                      active
);

  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int BIT_W  = $clog2(UART_DATA_BITS);

  ser_state_t                state_q, state_d;
  logic [BAUD_W-1:0]         baud_q, baud_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  logic baud_done;
  assign baud_done = (baud_q == BAUD_W'(CLK_DIV - 1));

  // txd is computed from the current state, so the line lags the state
  // register by one cycle; every bit therefore still lasts CLK_DIV cycles.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    txd_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (valid) begin
          shift_d  = tx_byte;
          baud_d   = '0;
          state_d  = S_START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_byte;
`endif
        end
      end
      S_START: begin
        txd_d = 1'b0;
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        txd_d = shift_q[0];
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          if (bit_q == BIT_W'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        txd_d = parity_q;
        if (baud_done) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign active = (state_q != S_IDLE);
  assign txd    = txd_q;

endmodule

`default_nettype wire

// File: rtl/uart_tx_axi.sv
// ============================================================================
// Module      : uart_tx_axi
// Description : UART transmit endpoint as a single-beat AXI write slave.
//               wdata[7:0] of each write is queued in a byte FIFO and sent
//               as 8N1 frames (8E1 with UART_TX_PARITY_EN).
// Revision    : 1.0 - initial release
// Macro       : UART_TX_PARITY_EN - enables the even-parity bit.
// Ports       : clk, rstn              - clock, synchronous active-low reset
//               awvalid/awready        - write address (address ignored)
//               wdata/wvalid/wready    - write data, only [7:0] used
//               wlast                  - ignored (single beat)
//               bvalid/bready/bresp    - write response, always OKAY
//               txd                    - UART serial out, idle high
//               busy                   - FIFO non-empty or frame in flight
// ============================================================================
`default_nettype none

module uart_tx_axi import uart_axi_pkg::*; #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic        wvalid,
  output logic        wready,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic        txd,
  output logic        busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wr_state_t                 wstate_q, wstate_d;
  logic [UART_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [UART_DATA_BITS-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      full_q, full_d;
  logic                      busy_q, busy_d;

  logic push, pop, ser_ready, ser_active;

  // Upper write-data bits and wlast carry no meaning for this endpoint.
  logic unused_ok;
  assign unused_ok = ^{wdata[31:UART_DATA_BITS], wlast};

  // Write FSM; handshake outputs depend on state only. wready uses the
  // registered full flag, so a pop while full frees a slot one cycle later.
  always_comb begin
    wstate_d = wstate_q;
    awready  = 1'b0;
    wready   = 1'b0;
    bvalid   = 1'b0;
    push     = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) wstate_d = W_DATA;
      end
      W_DATA: begin
        wready = !full_q;
        if (wvalid && !full_q) begin
          push     = 1'b1;
          wstate_d = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  assign pop = ser_ready && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata[UART_DATA_BITS-1:0];
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CNT_W'(FIFO_DEPTH));
    busy_d = (count_q != '0) || ser_active;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wstate_q <= W_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      busy_q   <= busy_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  uart_tx_serializer #(
    .CLK_DIV (CLK_DIV)
  ) u_ser (
    .clk     (clk),
    .rstn    (rstn),
    .tx_byte (mem_q[rd_ptr_q]),
    .valid   (count_q != '0),
    .ready   (ser_ready),
    .txd     (txd),
    .active  (ser_active)
  );

  assign bresp = AXI_RESP_OKAY;
  assign busy  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_axi.sv
// ============================================================================
// Module      : tb_uart_tx_axi
// Description : Self-checking bench for uart_tx_axi. A UART line receiver
//               decodes txd into bytes and start times; results are compared
//               against the bytes written and the frame timing rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_axi;

  localparam int CLK_DIV    = 16;
  localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC  = FRAME_BITS * CLK_DIV;

  logic        clk, rstn, awvalid, awready, wvalid, wready, wlast;
  logic        bvalid, bready, txd, busy;
  logic [31:0] wdata;
  logic [1:0]  bresp;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         st_q[$];
`ifdef UART_TX_PARITY_EN
  logic       last_par;
`endif

  uart_tx_axi #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rstn(rstn), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .txd(txd), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Line receiver: a falling txd starts a frame; every bit must hold for
  // CLK_DIV cycles. A reset during the frame abandons it.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && txd === 1'b0) begin
        logic [FRAME_BITS-1:0] bits;
        logic                  abort;
        logic                  stable;
        abort  = 1'b0;
        stable = 1'b1;
        bits   = '0;
        st_q.push_back(cyc);
        for (int i = 0; i < FRAME_CYC; i++) begin
          if (i > 0) @(negedge clk);
          if (rstn !== 1'b1) abort = 1'b1;
          if (abort) break;
          if (i % CLK_DIV == 0) bits[i / CLK_DIV] = txd;
          else if (txd !== bits[i / CLK_DIV]) stable = 1'b0;
        end
        if (!abort) begin
          chk("frame_stable", stable, 1'b1);
          chk("frame_start_stop", {bits[FRAME_BITS-1], bits[0]}, 2'b10);
`ifdef UART_TX_PARITY_EN
          chk("frame_parity", bits[9], ^bits[8:1]);
          last_par = bits[9];
`endif
          rx_q.push_back(bits[8:1]);
        end
      end
    end
  end

  // AW then W handshake; hs is the cycle count just after the W edge.
  task automatic axi_write(input logic [31:0] d, output int hs, output int stall);
    stall   = 0;
    awvalid = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      if (awready === 1'b1) break;
      @(negedge clk);
    end
    chk("aw_ready_seen", awready, 1'b1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid  = 1'b1;
    wdata   = d;
    for (int n = 0; n < 2000; n++) begin
      if (wready === 1'b1) break;
      stall++;
      @(negedge clk);
    end
    chk("w_ready_seen", wready, 1'b1);
    @(posedge clk); #1;
    hs     = cyc;
    wvalid = 1'b0;
    exp_q.push_back(d[7:0]);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (busy === 1'b0 && bvalid === 1'b0) break;
    end
    chk("idle_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rx_q.delete();
    st_q.delete();
    exp_q.delete();
  endtask

  task automatic check_rx();
    for (int n = 0; n < 20000; n++) begin
      if (rx_q.size() >= exp_q.size()) break;
      @(negedge clk);
    end
    chk("rx_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk("rx_byte", rx_q[i], exp_q[i]);
    end
  endtask

  initial begin
    int hs, h1, stall, target;
    logic ok;
    rstn = 1'b0; awvalid = 1'b0; wvalid = 1'b0; wdata = '0;
    bready = 1'b1; wlast = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_awready", awready, 1'b1);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_bresp", bresp, 2'b00);
    chk("rst_txd", txd, 1'b1);
    chk("rst_busy", busy, 1'b0);

    // Single write of 0x55: response pulse and start-bit latency.
    axi_write(32'h0000_0055, hs, stall);
    @(negedge clk);
    chk("t1_bvalid_hi", bvalid, 1'b1);
    chk("t1_bresp", bresp, 2'b00);
    @(negedge clk);
    chk("t1_bvalid_lo", bvalid, 1'b0);
    check_rx();
    chk("t1_start_latency", st_q[0], hs + 2);

    // Upper data bits are ignored.
    wait_idle();
    axi_write(32'hABCD_EF41, hs, stall);
    check_rx();
    chk("t2_low_byte", rx_q[0], 8'h41);

    // Five back-to-back writes fill the FIFO; the sixth stalls.
    wait_idle();
    for (int i = 0; i < 6; i++) begin
      axi_write($urandom, hs, stall);
      if (i == 0) h1 = hs;
    end
    chk("t3_first_popped", st_q[0], h1 + 2);
    chk("t3_sixth_stalled", stall > 0, 1'b1);
    chk("t3_sixth_release", hs, st_q[0] + FRAME_CYC + 1);
    for (int n = 0; n < 20000; n++) begin
      if (st_q.size() >= 6) break;
      @(negedge clk);
    end
    chk("t3_frames_started", st_q.size(), 6);
    for (int i = 1; i < 6; i++) begin
      chk("t3_frame_gap", st_q[i] - st_q[i-1], FRAME_CYC + 1);
    end
    target = st_q[5] + FRAME_CYC - 1;
    for (int n = 0; n < 20000; n++) begin
      if (cyc >= target) break;
      @(negedge clk);
    end
    chk("t3_busy_last_stop", busy, 1'b1);
    @(negedge clk);
    chk("t3_busy_drop", busy, 1'b0);
    check_rx();

    // Response back-pressure: bvalid holds, address is not accepted.
    wait_idle();
    bready = 1'b0;
    axi_write($urandom, hs, stall);
    awvalid = 1'b1;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bvalid !== 1'b1 || awready !== 1'b0) ok = 1'b0;
    end
    chk("t4_hold", ok, 1'b1);
    @(posedge clk); #1 bready = 1'b1;
    @(negedge clk);
    chk("t4_aw_blocked", awready, 1'b0);
    @(negedge clk);
    chk("t4_aw_open", awready, 1'b1);
    chk("t4_bvalid_done", bvalid, 1'b0);
    axi_write($urandom, hs, stall);
    check_rx();

    // Reset in the middle of data bit 3 with two bytes queued.
    wait_idle();
    for (int i = 0; i < 3; i++) axi_write($urandom, hs, stall);
    target = st_q[0] + 4 * CLK_DIV + CLK_DIV / 2;
    for (int n = 0; n < 2000; n++) begin
      if (cyc >= target) break;
      @(posedge clk); #1;
    end
    rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    chk("t5_txd", txd, 1'b1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_awready", awready, 1'b1);
    chk("t5_bvalid", bvalid, 1'b0);
    ok = 1'b1;
    repeat (3 * FRAME_CYC) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    chk("t5_line_quiet", ok, 1'b1);
    chk("t5_no_bytes", rx_q.size(), 0);
    chk("t5_one_start", st_q.size(), 1);

    // Random data with random response delays and gaps.
    wait_idle();
    for (int i = 0; i < 6; i++) begin
      int dly;
      dly = int'($urandom_range(0, 3));
      bready = (dly == 0);
      axi_write($urandom, hs, stall);
      repeat (dly) @(posedge clk);
      #1 bready = 1'b1;
      repeat ($urandom_range(0, 20)) @(posedge clk);
      #1;
    end
    check_rx();

`ifdef UART_TX_PARITY_EN
    wait_idle();
    axi_write(32'h0000_0007, hs, stall);
    check_rx();
    chk("t7_parity_bit", last_par, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
